// File: rtl/serial_subtracter.sv
// serial_subtracter: computes a - b - bin one DIGIT-bit slice per clock,
// LSB first, with a registered borrow chain and a start/busy/done handshake.
// STEPS = WIDTH/DIGIT cycles per operation; DIGIT = WIDTH gives a
// single-step registered subtracter.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the signed-overflow
// output ovf and its register.
module serial_subtracter #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;

    // Per-step combinational results
    logic [DIGIT:0]   step_res_d;
    logic [DIGIT-1:0] slice_d;
    logic             borrow_d;
    logic [WIDTH-1:0] work_d;
    logic             last_step_s;

    // One slice of the subtraction plus insertion of its result at the MSB end
    always_comb begin
        step_res_d = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                     - {{DIGIT{1'b0}}, borrow_q};
        slice_d    = step_res_d[DIGIT-1:0];
        borrow_d   = step_res_d[DIGIT];
        work_d     = work_q >> DIGIT;
        work_d[WIDTH-1 -: DIGIT] = slice_d;
        if (cnt_q == CW'(STEPS - 1)) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic ovf_q;
    logic msb_bin_s;

    // Borrow into the MSB of the top slice: a result bit is a ^ b ^ borrow-in,
    // so the borrow-in falls out of the DIGIT-1-bit sub-subtraction below it
    // without a second subtractor.
    always_comb begin
        msb_bin_s = step_res_d[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    end

    assign ovf = ovf_q;
`endif

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            work_q   <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        work_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    work_q   <= work_d;
                    borrow_q <= borrow_d;
                    if (last_step_s) begin
                        cnt_q   <= '0;
                        diff_q  <= work_d;
                        bout_q  <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        ovf_q   <= msb_bin_s ^ borrow_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtracter.sv
// Directed self-checking bench for serial_subtracter. Three instances:
// WIDTH=1/DIGIT=1, WIDTH=8/DIGIT=1 and WIDTH=8/DIGIT=4. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_serial_subtracter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       st1, bin1, busy1, done1, bout1;
    logic [0:0] a1, b1, diff1;
    logic       st8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       st4, bin4, busy4, done4, bout4;
    logic [7:0] a4, b4, diff4;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic       ovf1, ovf8, ovf4;
`endif

    serial_subtracter #(.WIDTH(1), .DIGIT(1)) u_w1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_OVERFLOW_EN
        , .ovf(ovf1)
`endif
    );

    serial_subtracter #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVERFLOW_EN
        , .ovf(ovf8)
`endif
    );

    serial_subtracter #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVERFLOW_EN
        , .ovf(ovf4)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // sel: 0 = W1, 1 = W8D1, 2 = W8D4
    task automatic drive(input int sel, input logic s, input logic [7:0] av,
                         input logic [7:0] bv, input logic binv);
        case (sel)
            0: begin st1 = s; a1 = av[0]; b1 = bv[0]; bin1 = binv; end
            1: begin st8 = s; a8 = av;    b8 = bv;    bin8 = binv; end
            default: begin st4 = s; a4 = av; b4 = bv; bin4 = binv; end
        endcase
    endtask

    // {busy, done, bout, diff[7:0]}
    function automatic logic [10:0] obs_of(input int sel);
        case (sel)
            0:       return {busy1, done1, bout1, 7'b0, diff1};
            1:       return {busy8, done8, bout8, diff8};
            default: return {busy4, done4, bout4, diff4};
        endcase
    endfunction

`ifdef SERIAL_SUB_OVERFLOW_EN
    function automatic logic ovf_of(input int sel);
        case (sel)
            0:       return ovf1;
            1:       return ovf8;
            default: return ovf4;
        endcase
    endfunction
`endif

    // One operation: accept, count edges to done, check result.
    task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic binv, input logic [7:0] exp_d, input logic exp_b,
                          input int exp_lat, input int exp_ovf, input string tag);
        logic [10:0] o;
        int lat;
        @(negedge clk);
        drive(sel, 1'b1, av, bv, binv);
        @(negedge clk);
        drive(sel, 1'b0, av, bv, binv);
        o = obs_of(sel);
        check({tag, ".busy"}, {31'b0, o[10]}, 32'd1);
        lat = 0;
        while (o[9] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            o = obs_of(sel);
        end
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".diff"}, {24'b0, o[7:0]}, {24'b0, exp_d});
        check({tag, ".bout"}, {31'b0, o[8]}, {31'b0, exp_b});
`ifdef SERIAL_SUB_OVERFLOW_EN
        if (exp_ovf >= 0) check({tag, ".ovf"}, {31'b0, ovf_of(sel)}, exp_ovf);
`endif
    endtask

    initial begin
        logic [7:0]  d_tbl;
        logic [7:0]  b_tbl;
        logic [10:0] o;
        int lat;
        int gap;
        int cnt_done;

        rst = 1'b0;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
        #1 rst = 1'b1;
        #2;
        check("rst.w1",   {21'b0, obs_of(0)}, 32'd0);
        check("rst.w8d1", {21'b0, obs_of(1)}, 32'd0);
        check("rst.w8d4", {21'b0, obs_of(2)}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("rst.ovf", {31'b0, ovf_of(1)}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Full-subtracter truth table, index = {a, b, bin}
        d_tbl = 8'b1001_0110;
        b_tbl = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            run_op(0, {7'b0, i[2]}, {7'b0, i[1]}, i[0], {7'b0, d_tbl[i]}, b_tbl[i],
                   1, -1, $sformatf("w1_%0d", i));
        end

        // WIDTH=8, DIGIT=1
        run_op(1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 8, 0, "d1_05m03");
        run_op(1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 8, 0, "d1_00m01");
        run_op(1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 8, 0, "d1_10m0F_b");
        run_op(1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 8, 1, "d1_80m01");
        run_op(1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 8, 1, "d1_7Fm FF");

        // WIDTH=8, DIGIT=4
        run_op(2, 8'h3C, 8'hC3, 1'b0, 8'h79, 1'b1, 2, 0, "d4_3CmC3");
        run_op(2, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 2, 1, "d4_80m01");
        run_op(2, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 2, 1, "d4_7FmFF");

        // Back-to-back on DIGIT=4: start held through DONE
        @(negedge clk);
        drive(2, 1'b1, 8'h3C, 8'hC3, 1'b0);
        @(negedge clk);
        drive(2, 1'b1, 8'h12, 8'h34, 1'b0);
        o = obs_of(2);
        check("b2b.busy", {31'b0, o[10]}, 32'd1);
        lat = 0;
        while (o[9] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            o = obs_of(2);
        end
        check("b2b.lat1", lat, 32'd2);
        check("b2b.diff1", {24'b0, o[7:0]}, 32'h79);
        gap = 0;
        @(negedge clk);
        gap++;
        drive(2, 1'b0, 8'h12, 8'h34, 1'b0);
        o = obs_of(2);
        check("b2b.rebusy", {30'b0, o[10:9]}, 32'd2);
        check("b2b.hold", {24'b0, o[7:0]}, 32'h79);
        while (o[9] !== 1'b1 && gap < 40) begin
            @(negedge clk);
            gap++;
            o = obs_of(2);
        end
        check("b2b.gap", gap, 32'd3);
        check("b2b.diff2", {24'b0, o[7:0]}, 32'hDE);
        check("b2b.bout2", {31'b0, o[8]}, 32'd1);

        // start pulsed mid-RUN is ignored
        @(negedge clk);
        drive(1, 1'b1, 8'h05, 8'h03, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 8'h05, 8'h03, 1'b0);
        o = obs_of(1);
        lat = 0;
        while (o[9] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 3) drive(1, 1'b1, 8'hAA, 8'h11, 1'b1);
            else          drive(1, 1'b0, 8'hAA, 8'h11, 1'b1);
            o = obs_of(1);
        end
        check("mid.lat", lat, 32'd8);
        check("mid.diff", {24'b0, o[7:0]}, 32'h02);
        check("mid.bout", {31'b0, o[8]}, 32'd0);
        @(negedge clk);
        o = obs_of(1);
        check("mid.idle", {30'b0, o[10:9]}, 32'd0);

        // Leave a nonzero result with bout=1 before the abort test
        run_op(1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8, 0, "d1_FFmFF_b");

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        drive(1, 1'b1, 8'h10, 8'h01, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 8'h10, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        o = obs_of(1);
        check("abort.prebusy", {31'b0, o[10]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort.async", {21'b0, obs_of(1)}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        repeat (12) begin
            @(negedge clk);
            o = obs_of(1);
            if (o[9] === 1'b1 || o[10] === 1'b1) cnt_done++;
        end
        check("abort.nodone", cnt_done, 32'd0);
        run_op(1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 8, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
